regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32: register data width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; register count DEPTH = 2^ADDR_W.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 reads as zero, ignores writes and is never busy.
REQ-004 Parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to matching reads.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 rd_addr_a, rd_addr_b  in  ADDR_W each  read port addresses.
REQ-008 rd_data_a, rd_data_b  out  DATA_W each  combinational read data.
REQ-009 rd_busy_a, rd_busy_b  out  1 each  addressed register has an outstanding producer.
REQ-010 wr_en_0, wr_en_1  in  1 each  write enables; port 1 has higher priority.
REQ-011 wr_addr_0, wr_addr_1  in  ADDR_W each  write addresses.
REQ-012 wr_data_0, wr_data_1  in  DATA_W each  write data.
REQ-013 iss_en  in  1  marks iss_addr as having an outstanding producer.
REQ-014 iss_addr  in  ADDR_W  register to mark busy.
REQ-015 busy_cnt  out  ADDR_W+1  number of registers currently busy.

Function
REQ-016 Storage SHALL be DEPTH x DATA_W registers plus a DEPTH-bit busy vector.
REQ-017 On a rising edge with wr_en_k=1, RF[wr_addr_k] SHALL take wr_data_k; 1-cycle write latency.
REQ-018 Both write ports enabled with equal addresses: port 1 data SHALL be stored and port 0 discarded.
REQ-019 Reads SHALL be combinational with 0-cycle latency: rd_data_x = RF[rd_addr_x].
REQ-020 With BYPASS=1 and a read address equal to an enabled write address, rd_data_x SHALL equal that write's data, using port 1 if both match; with BYPASS=0, the stored value SHALL be returned.
REQ-021 With ZERO_REG=1, address 0 SHALL read as all zeros, with rd_busy_x=0, irrespective of writes, bypass or issue.
REQ-022 A write to register r SHALL clear busy[r] on the same edge.
REQ-023 iss_en=1 SHALL set busy[iss_addr] on the edge; if the same edge also writes iss_addr, the set SHALL win.
REQ-024 rd_busy_x SHALL equal busy[rd_addr_x], except with BYPASS=1 it SHALL be 0 when a same-cycle write matches rd_addr_x and iss_en does not target it.
REQ-025 busy_cnt SHALL be registered, equal to the population count of busy after each edge, and never exceed DEPTH.
REQ-026 Re-issuing an already busy register SHALL leave it busy and SHALL NOT change busy_cnt.
REQ-027 Out-of-range addresses cannot occur; all ADDR_W codes SHALL be valid.

Reset
REQ-028 rst=0 SHALL immediately, without a clock, clear all RF entries, the busy vector and busy_cnt to 0.
REQ-029 While rst=0, writes and issues SHALL be ignored; rd_data_x SHALL read 0 except forwarded data when BYPASS=1 and a write matches.
REQ-030 A reset asserted mid-operation SHALL discard all pending busy marks; the first edge after deassertion SHALL behave as a normal cycle.

Verification
REQ-031 Reset, then write 0xDEADBEEF to r5 via port 0 -> next cycle rd_data_a(r5)=0xDEADBEEF; before that edge, with BYPASS=1 it equals 0xDEADBEEF, with BYPASS=0 it equals 0.
REQ-032 Same edge: wr port 0 r7=0x11111111, port 1 r7=0x22222222 -> r7 reads 0x22222222; the same-cycle bypass also shows 0x22222222.
REQ-033 ZERO_REG=1: write 0xFFFFFFFF to r0 and issue r0 -> rd_data=0, rd_busy=0, busy_cnt=0.
REQ-034 Issue r3, then r4, then r3 again -> busy_cnt 1,2,2; write r3 -> busy_cnt 1; issue and write r4 on the same edge -> r4 stays busy, busy_cnt 1.
REQ-035 With r9 busy, drive rd_addr_b=9 and write r9 in the same cycle -> rd_busy_b=0 (BYPASS=1) or 1 (BYPASS=0).
REQ-036 Fill r1..r31 with data and busy bits, assert rst=0 between edges -> all outputs become 0 at once with no clock edge; the post-release write to r2 works normally.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-ported register file: two combinational read ports, two write ports and
// a busy scoreboard for registers that are waiting on an outstanding producer.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en_0,
  input  logic              wr_en_1,
  input  logic [ADDR_W-1:0] wr_addr_0,
  input  logic [ADDR_W-1:0] wr_addr_1,
  input  logic [DATA_W-1:0] wr_data_0,
  input  logic [DATA_W-1:0] wr_data_1,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  busy, busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              we_0, we_1;
  logic              zero_a, zero_b, hit_a0, hit_a1, hit_b0, hit_b1, iss_a, iss_b;

  always_comb begin
    we_0 = wr_en_0 && !(ZERO_REG != 0 && wr_addr_0 == '0);
    we_1 = wr_en_1 && !(ZERO_REG != 0 && wr_addr_1 == '0);
  end

  // Issue is applied after the write clears so a same-edge set wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_en_0) busy_nxt[wr_addr_0] = 1'b0;
    if (wr_en_1) busy_nxt[wr_addr_1] = 1'b0;
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (we_0) rf[wr_addr_0] <= wr_data_0;
      if (we_1) rf[wr_addr_1] <= wr_data_1;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    zero_a = (ZERO_REG != 0) && (rd_addr_a == '0);
    zero_b = (ZERO_REG != 0) && (rd_addr_b == '0);
    hit_a0 = (BYPASS != 0) && wr_en_0 && (wr_addr_0 == rd_addr_a);
    hit_a1 = (BYPASS != 0) && wr_en_1 && (wr_addr_1 == rd_addr_a);
    hit_b0 = (BYPASS != 0) && wr_en_0 && (wr_addr_0 == rd_addr_b);
    hit_b1 = (BYPASS != 0) && wr_en_1 && (wr_addr_1 == rd_addr_b);
    iss_a  = iss_en && (iss_addr == rd_addr_a);
    iss_b  = iss_en && (iss_addr == rd_addr_b);
  end

  // Port 1 forwarding takes precedence, matching the write priority.
  always_comb begin
    rd_data_a = zero_a ? '0 : hit_a1 ? wr_data_1 : hit_a0 ? wr_data_0 : rf[rd_addr_a];
    rd_data_b = zero_b ? '0 : hit_b1 ? wr_data_1 : hit_b0 ? wr_data_0 : rf[rd_addr_b];
    rd_busy_a = !zero_a && !((hit_a0 || hit_a1) && !iss_a) && busy[rd_addr_a];
    rd_busy_b = !zero_b && !((hit_b0 || hit_b1) && !iss_b) && busy[rd_addr_b];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: reference model of register contents and busy marks,
// checked every falling edge, plus directed scenarios with literal expectations.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr_0, wr_addr_1, iss_addr;
  logic [31:0] rd_data_a, rd_data_b, wr_data_0, wr_data_1;
  logic        rd_busy_a, rd_busy_b, wr_en_0, wr_en_1, iss_en;
  logic [5:0]  busy_cnt;

  int errors = 0;
  int checks = 0;

  bit [31:0] m_rf [32];
  bit        m_busy [32];
  int        m_cnt;

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr_en_0(wr_en_0), .wr_en_1(wr_en_1),
    .wr_addr_0(wr_addr_0), .wr_addr_1(wr_addr_1),
    .wr_data_0(wr_data_0), .wr_data_1(wr_data_1),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wr_en_1 && wr_addr_1 == a) return wr_data_1;
    if (wr_en_0 && wr_addr_0 == a) return wr_data_0;
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    bit wr_hit;
    wr_hit = (wr_en_0 && wr_addr_0 == a) || (wr_en_1 && wr_addr_1 == a);
    if (a == 5'd0) return 1'b0;
    if (wr_hit && !(iss_en && iss_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  // Reference model: state after each edge, cleared instantly by reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_rf[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_cnt = 0;
    end else begin
      if (wr_en_0) begin m_rf[wr_addr_0] = wr_data_0; m_busy[wr_addr_0] = 1'b0; end
      if (wr_en_1) begin m_rf[wr_addr_1] = wr_data_1; m_busy[wr_addr_1] = 1'b0; end
      if (iss_en) m_busy[iss_addr] = 1'b1;
      m_rf[0] = '0;
      m_busy[0] = 1'b0;
      m_cnt = 0;
      for (int i = 0; i < 32; i++) m_cnt += int'(m_busy[i]);
    end
  end

  always @(negedge clk) begin
    chk("model rd_data_a", rd_data_a, exp_data(rd_addr_a));
    chk("model rd_data_b", rd_data_b, exp_data(rd_addr_b));
    chk("model rd_busy_a", {31'd0, rd_busy_a}, {31'd0, exp_busy(rd_addr_a)});
    chk("model rd_busy_b", {31'd0, rd_busy_b}, {31'd0, exp_busy(rd_addr_b)});
    chk("model busy_cnt", {26'd0, busy_cnt}, 32'(m_cnt));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en_0 = 0; wr_en_1 = 0; iss_en = 0;
    wr_addr_0 = '0; wr_addr_1 = '0; iss_addr = '0;
    wr_data_0 = '0; wr_data_1 = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rd_addr_a = 5'd5; rd_addr_b = 5'd0;
    #2 rst = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    step();
    #3;
    chk("reset busy_cnt", {26'd0, busy_cnt}, 32'd0);
    chk("reset rd_data_a", rd_data_a, 32'd0);

    // Basic write with same-cycle forwarding
    step();
    wr_en_0 = 1; wr_addr_0 = 5'd5; wr_data_0 = 32'hDEADBEEF; rd_addr_a = 5'd5;
    #3 chk("r5 bypass", rd_data_a, 32'hDEADBEEF);
    step(); idle();
    #3 chk("r5 stored", rd_data_a, 32'hDEADBEEF);

    // Port 1 wins a same-address collision
    step();
    wr_en_0 = 1; wr_addr_0 = 5'd7; wr_data_0 = 32'h11111111;
    wr_en_1 = 1; wr_addr_1 = 5'd7; wr_data_1 = 32'h22222222;
    rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    #3 chk("r7 bypass", rd_data_b, 32'h22222222);
    step(); idle();
    #3 chk("r7 stored", rd_data_a, 32'h22222222);

    // Register 0 is hardwired
    step();
    wr_en_1 = 1; wr_addr_1 = 5'd0; wr_data_1 = 32'hFFFFFFFF;
    iss_en = 1; iss_addr = 5'd0; rd_addr_a = 5'd0;
    #3 chk("r0 data", rd_data_a, 32'd0);
    chk("r0 busy", {31'd0, rd_busy_a}, 32'd0);
    step(); idle();
    #3 chk("r0 busy_cnt", {26'd0, busy_cnt}, 32'd0);
    chk("r0 after", rd_data_a, 32'd0);

    // Busy scoreboard sequence
    step(); iss_en = 1; iss_addr = 5'd3; rd_addr_a = 5'd3; rd_addr_b = 5'd4;
    step(); iss_addr = 5'd4;
    #3 chk("cnt after r3", {26'd0, busy_cnt}, 32'd1);
    step(); iss_addr = 5'd3;
    #3 chk("cnt after r4", {26'd0, busy_cnt}, 32'd2);
    step(); idle(); wr_en_0 = 1; wr_addr_0 = 5'd3; wr_data_0 = 32'h33;
    #3 chk("cnt reissue r3", {26'd0, busy_cnt}, 32'd2);
    step(); idle(); wr_en_0 = 1; wr_addr_0 = 5'd4; wr_data_0 = 32'h44; iss_en = 1; iss_addr = 5'd4;
    #3 chk("cnt write r3", {26'd0, busy_cnt}, 32'd1);
    chk("r4 busy iss+wr", {31'd0, rd_busy_b}, 32'd1);
    step(); idle();
    #3 chk("cnt iss+wr r4", {26'd0, busy_cnt}, 32'd1);
    chk("r4 still busy", {31'd0, rd_busy_b}, 32'd1);

    // Busy bypass on a same-cycle write
    step(); iss_en = 1; iss_addr = 5'd9; rd_addr_b = 5'd9;
    step(); idle();
    #3 chk("r9 busy", {31'd0, rd_busy_b}, 32'd1);
    step(); wr_en_0 = 1; wr_addr_0 = 5'd9; wr_data_0 = 32'h99;
    #3 chk("r9 busy bypass", {31'd0, rd_busy_b}, 32'd0);
    step(); idle();
    #3 chk("r9 cnt", {26'd0, busy_cnt}, 32'd1);

    // Fill r1..r31 alternating write ports, marking each busy
    for (int i = 1; i < 32; i++) begin
      step(); idle();
      if (i % 2 == 1) begin
        wr_en_0 = 1; wr_addr_0 = 5'(i); wr_data_0 = {4{8'(i)}};
      end else begin
        wr_en_1 = 1; wr_addr_1 = 5'(i); wr_data_1 = {4{8'(i)}};
      end
      iss_en = 1; iss_addr = 5'(i);
      rd_addr_a = 5'(i); rd_addr_b = 5'(i - 1);
    end
    step(); idle();
    rd_addr_a = 5'd31; rd_addr_b = 5'd1;
    #2 chk("fill r31", rd_data_a, 32'h1F1F1F1F);
    chk("fill busy", {31'd0, rd_busy_a}, 32'd1);
    chk("fill cnt", {26'd0, busy_cnt}, 32'd31);
    #1 rst = 1'b0;
    #1 chk("async rst data a", rd_data_a, 32'd0);
    chk("async rst data b", rd_data_b, 32'd0);
    chk("async rst busy", {31'd0, rd_busy_a}, 32'd0);
    chk("async rst cnt", {26'd0, busy_cnt}, 32'd0);

    // Writes and issues are ignored while in reset, but still forward
    step();
    wr_en_0 = 1; wr_addr_0 = 5'd2; wr_data_0 = 32'h12345678;
    iss_en = 1; iss_addr = 5'd2; rd_addr_a = 5'd2;
    #3 chk("rst bypass", rd_data_a, 32'h12345678);
    step(); idle();
    #3 chk("rst write ignored", rd_data_a, 32'd0);
    chk("rst iss ignored", {26'd0, busy_cnt}, 32'd0);
    #1 rst = 1'b1;

    step();
    wr_en_0 = 1; wr_addr_0 = 5'd2; wr_data_0 = 32'hCAFEF00D;
    step(); idle();
    #3 chk("post rst r2", rd_data_a, 32'hCAFEF00D);
    chk("post rst cnt", {26'd0, busy_cnt}, 32'd0);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
